// File: rtl/lenet_pkg.sv
// Shared LeNet definitions: default F3 map geometry and the F3 read FSM encoding.
package lenet_pkg;

  localparam int LN_IMG_W = 14;
  localparam int LN_K     = 5;
  localparam int LN_OUT   = LN_IMG_W - LN_K + 1;
  localparam int F3_CH    = 6;

  typedef enum logic [1:0] {
    RD_IDLE  = 2'd0,
    RD_RUN   = 2'd1,
    RD_DRAIN = 2'd2
  } rd_state_t;

  typedef struct packed {
    logic first;
    logic last;
    logic frame_last;
  } px_flags_t;

endpackage

// File: rtl/f3_skid_buf.sv
// Two-entry registered output buffer; dout always shows the oldest entry.
module f3_skid_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic         out_valid,
  output logic [W-1:0] dout,
  output logic [1:0]   count
);

  logic [W-1:0] head, tail;
  logic [1:0]   cnt;
  logic         do_pop;

  assign do_pop    = pop && (cnt != 2'd0);
  assign out_valid = (cnt != 2'd0);
  assign dout      = head;
  assign count     = cnt;

  // The issuer's credit check guarantees push never lands on a full buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head <= '0;
      tail <= '0;
      cnt  <= 2'd0;
    end else begin
      case ({push, do_pop})
        2'b10: begin
          if (cnt == 2'd0) head <= din;
          else             tail <= din;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          head <= tail;
          cnt  <= cnt - 2'd1;
        end
        2'b11: begin
          if (cnt == 2'd1) begin
            head <= din;
          end else begin
            head <= tail;
            tail <= din;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/f3_rd_ctrl.sv
// F3 window reader: scans every KxK window of the F3 map and streams 6-channel pixels.
// Optional feature: F3_RD_PERF_CNT_EN adds the stall_cnt output.
module f3_rd_ctrl
  import lenet_pkg::*;
#(
  parameter int IMG_W = LN_IMG_W,
  parameter int K     = LN_K,
  parameter int DW    = 16,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] f3_raddr,
  input  logic [DW-1:0] f3_1_rdata,
  input  logic [DW-1:0] f3_2_rdata,
  input  logic [DW-1:0] f3_3_rdata,
  input  logic [DW-1:0] f3_4_rdata,
  input  logic [DW-1:0] f3_5_rdata,
  input  logic [DW-1:0] f3_6_rdata,
  output logic [DW-1:0] px_1_data,
  output logic [DW-1:0] px_2_data,
  output logic [DW-1:0] px_3_data,
  output logic [DW-1:0] px_4_data,
  output logic [DW-1:0] px_5_data,
  output logic [DW-1:0] px_6_data,
  output logic          px_valid,
  input  logic          px_ready,
  output logic          px_first,
  output logic          px_last,
  output logic          frame_last
`ifdef F3_RD_PERF_CNT_EN
  ,
  output logic [15:0]   stall_cnt
`endif
);

  localparam int OUT    = IMG_W - K + 1;
  localparam int PW     = (OUT > 1) ? $clog2(OUT) : 1;
  localparam int KW     = (K > 1) ? $clog2(K) : 1;
  localparam int BW     = $bits(px_flags_t) + F3_CH * DW;
  localparam int STAGES = 1;

  localparam logic [PW-1:0] POS_MAX  = PW'(OUT - 1);
  localparam logic [KW-1:0] K_MAX    = KW'(K - 1);
  localparam logic [AW-1:0] ROW_STEP = AW'(IMG_W);
  // Last column of a window row to column 0 of the next: IMG_W - (OUT-1) == K.
  localparam logic [AW-1:0] WROW_STEP = AW'(K);

  rd_state_t state, state_nx;

  logic [PW-1:0] row, col;
  logic [KW-1:0] kr, kc;
  logic [AW-1:0] addr, line_base, win_base;

  logic [STAGES:0] vld_pipe;
  px_flags_t       issue_flags, rd_flags, out_flags;
  logic            issue, pop, last_issue, scan_start;
  logic [1:0]      occ;
  logic [2:0]      pending;
  logic            buf_valid;
  logic [BW-1:0]   buf_din, buf_dout;

  logic [F3_CH-1:0][DW-1:0] rdata, px_data;

  assign rdata = {f3_6_rdata, f3_5_rdata, f3_4_rdata, f3_3_rdata, f3_2_rdata, f3_1_rdata};

  assign scan_start = (state == RD_IDLE) && start;
  assign pop        = buf_valid && px_ready;
  assign pending    = {1'b0, occ} + {2'b0, vld_pipe[STAGES]};
  assign issue      = (state == RD_RUN) && (pop ? (pending < 3'd3) : (pending < 3'd2));
  assign last_issue = issue && issue_flags.frame_last;
  assign f3_raddr   = addr;
  assign busy       = (state != RD_IDLE);

  always_comb begin
    issue_flags            = '0;
    issue_flags.first      = (kr == '0) && (kc == '0);
    issue_flags.last       = (kr == K_MAX) && (kc == K_MAX);
    issue_flags.frame_last = issue_flags.last && (row == POS_MAX) && (col == POS_MAX);
  end

  // FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RD_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      RD_IDLE:  if (start) state_nx = RD_RUN;
      RD_RUN:   if (last_issue) state_nx = RD_DRAIN;
      RD_DRAIN: if (pop && out_flags.frame_last) state_nx = RD_IDLE;
      default:  state_nx = RD_IDLE;
    endcase
  end

  // Address generation: window base, kernel-row base and pixel address tracked by adders.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row <= '0; col <= '0; kr <= '0; kc <= '0;
      addr <= '0; line_base <= '0; win_base <= '0;
    end else if (scan_start) begin
      row <= '0; col <= '0; kr <= '0; kc <= '0;
      addr <= '0; line_base <= '0; win_base <= '0;
    end else if (issue) begin
      if (kc != K_MAX) begin
        kc   <= kc + KW'(1);
        addr <= addr + AW'(1);
      end else begin
        kc <= '0;
        if (kr != K_MAX) begin
          kr        <= kr + KW'(1);
          line_base <= line_base + ROW_STEP;
          addr      <= line_base + ROW_STEP;
        end else begin
          kr <= '0;
          if (col != POS_MAX) begin
            col       <= col + PW'(1);
            win_base  <= win_base + AW'(1);
            line_base <= win_base + AW'(1);
            addr      <= win_base + AW'(1);
          end else if (row != POS_MAX) begin
            col       <= '0;
            row       <= row + PW'(1);
            win_base  <= win_base + WROW_STEP;
            line_base <= win_base + WROW_STEP;
            addr      <= win_base + WROW_STEP;
          end else begin
            col <= '0; row <= '0;
            win_base <= '0; line_base <= '0; addr <= '0;
          end
        end
      end
    end
  end

  // Read-latency pipe: flags ride alongside the outstanding read.
  assign vld_pipe[0] = issue;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe[STAGES:1] <= '0;
      rd_flags           <= '0;
      done               <= 1'b0;
    end else begin
      vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
      rd_flags           <= issue_flags;
      done               <= pop && out_flags.frame_last;
    end
  end

  assign buf_din = {rd_flags, rdata};

  f3_skid_buf #(.W(BW)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (vld_pipe[STAGES]),
    .din       (buf_din),
    .pop       (pop),
    .out_valid (buf_valid),
    .dout      (buf_dout),
    .count     (occ)
  );

  assign {out_flags, px_data} = buf_dout;

  assign px_valid   = buf_valid;
  assign px_first   = out_flags.first;
  assign px_last    = out_flags.last;
  assign frame_last = out_flags.frame_last;
  assign px_1_data  = px_data[0];
  assign px_2_data  = px_data[1];
  assign px_3_data  = px_data[2];
  assign px_4_data  = px_data[3];
  assign px_5_data  = px_data[4];
  assign px_6_data  = px_data[5];

`ifdef F3_RD_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                            stall_cnt <= '0;
    else if (scan_start)                                   stall_cnt <= '0;
    else if (px_valid && !px_ready && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
  end
`endif

endmodule
